pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage MIPS pipeline around the main decoder. Detects load-use
//  hazards, taken-branch/jump redirects and data-memory wait states. Drives the
//  PC / IF-ID / ID-EX / EX-MEM enable, flush and bubble controls.
//  Keeps saturating stall and flush statistics counters.
// PARAMETERS
//  CNT_W     16  width of the stall_cnt and flush_cnt statistics counters
//  MAX_WAIT  15  MEM_WAIT cycles tolerated before mem_timeout is set (1..255)
// PORTS
//  clk              in   1      pipeline clock; all state updates on rising edge
//  rst_n            in   1      synchronous, active-low reset
//  id_op            in   6      opcode in ID (R=0, beq=4, lw=35, sw=43, j=2, addi=8, ori=13)
//  id_rs            in   5      rs field of the ID instruction
//  id_rt            in   5      rt field of the ID instruction
//  ex_mem_read      in   1      instruction in EX is lw
//  ex_rt            in   5      destination rt of the instruction in EX
//  ex_branch_taken  in   1      beq in EX resolved taken
//  mem_req          in   1      MEM stage holds lw/sw and accesses data memory
//  mem_ready        in   1      data memory completes the access this cycle
//  pc_write         out  1      PC register load enable
//  ifid_write       out  1      IF/ID register load enable
//  ifid_flush       out  1      IF/ID loads a nop
//  idex_bubble      out  1      ID/EX control fields are zeroed (bubble)
//  exmem_hold       out  1      EX/MEM and MEM/WB registers are held
//  mem_timeout      out  1      sticky error: wait exceeded MAX_WAIT
//  stall_cnt        out  CNT_W  cycles with pc_write=0, saturating
//  flush_cnt        out  CNT_W  cycles with ifid_flush=1, saturating
// BEHAVIOUR
//  States: RUN, MEM_WAIT, LU_STALL. The state and the counters are registered.
//   Control outputs are combinational from the state and the inputs (0 latency).
//  Default, no event: pc_write=1, ifid_write=1, flush/bubble/hold=0.
//  Load-use condition (lu):
//   - ex_mem_read && ex_rt!=0, and
//   - ex_rt==id_rs, or ex_rt==id_rt with id_op in {0,4,43} (rt is read).
//  RUN, priority high->low:
//   1 mem_req && !mem_ready:
//      pc_write=0, ifid_write=0, exmem_hold=1, no bubble, no flush.
//      Next state MEM_WAIT; wait_cnt<=1.
//   2 ex_branch_taken:
//      pc_write=1, ifid_flush=1, idex_bubble=1. Stay RUN.
//      lu and j in the same cycle are discarded, because ID is flushed.
//   3 lu:
//      pc_write=0, ifid_write=0, idex_bubble=1. Next state LU_STALL.
//   4 id_op==2 (j):
//      ifid_flush=1, pc_write=1. Stay RUN.
//  MEM_WAIT:
//   - While !mem_ready: the outputs are frozen as in RUN case 1, and wait_cnt
//     increments, saturating at 255.
//   - When wait_cnt reaches MAX_WAIT with !mem_ready, mem_timeout<=1. The pipeline
//     keeps waiting, and mem_timeout clears only on reset.
//   - mem_ready=1: the outputs take the default values (the access retires), and
//     the next state is RUN. The RUN rules are not evaluated in that cycle.
//     branch, lu and j are re-evaluated next cycle, because EX and ID were held.
//   - ex_branch_taken, lu and j are ignored while in MEM_WAIT.
//  LU_STALL:
//   - Exactly one cycle. The default outputs apply, except that a MEM wait
//     (RUN rule 1) still takes priority and moves to MEM_WAIT.
//   - lu is not re-detected in this cycle (EX now holds the bubble).
//   - A branch or j is handled by the RUN rules 2 and 4. Next state RUN.
//  Counters:
//   - stall_cnt += 1 on every cycle with pc_write=0.
//   - flush_cnt += 1 on every cycle with ifid_flush=1.
//   - Both hold at 2^CNT_W-1 and never wrap.
//  Reset:
//   - While rst_n=0 at the clock edge: state<=RUN, wait_cnt<=0, counters<=0,
//     mem_timeout<=0.
//   - During a reset cycle the outputs are forced to the defaults
//     (pc_write=1, ifid_write=1, others 0), whatever the inputs.
//   - A reset during MEM_WAIT or LU_STALL aborts the stall immediately.
// TESTING
//  T1 ex_mem_read=1, ex_rt=5, id_op=0, id_rt=5 -> one cycle pc_write=0, idex_bubble=1,
//     then default; stall_cnt=1
//  T2 same, with ex_rt=0 or id_op=8 and id_rt=5 (no rs match) -> no stall
//  T3 ex_branch_taken=1 together with lu active -> ifid_flush=1, idex_bubble=1,
//     pc_write=1; flush_cnt=1, stall_cnt=0
//  T4 mem_req=1, mem_ready=0 for 3 cycles, then 1 -> exmem_hold=1 for 3 cycles, release
//     on the 4th; stall_cnt=3
//  T5 MAX_WAIT=4, mem_ready held 0 for 6 cycles -> mem_timeout rises after cycle 4,
//     stays 1 until rst_n=0
//  T6 rst_n=0 pulse while in MEM_WAIT; CNT_W=2 with 5 stall cycles -> state RUN and
//     outputs at defaults; stall_cnt saturates at 3

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard, redirect and memory-wait sequencer for a 5-stage MIPS pipeline
module pipeline_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_LU_STALL
    } state_t;

    localparam logic [7:0]       LP_MAX_WAIT = 8'(MAX_WAIT);
    localparam logic [7:0]       LP_WAIT_SAT = 8'hFF;
    localparam logic [CNT_W-1:0] LP_CNT_SAT  = {CNT_W{1'b1}};

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_J     = 6'd2;

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    state_t     w_next_state;
    logic       w_rt_read;
    logic       w_lu;
    logic       w_mem_stall;
    logic       w_is_j;
    logic       w_wait_active;
    logic [7:0] w_wait_next;
    logic       w_pc_write;
    logic       w_ifid_write;
    logic       w_ifid_flush;
    logic       w_idex_bubble;
    logic       w_exmem_hold;

    // rt is a source operand only for R-type, beq and sw; otherwise it is the destination.
    assign w_rt_read   = (id_op == OP_RTYPE) || (id_op == OP_BEQ) || (id_op == OP_SW);
    assign w_lu        = ex_mem_read && (ex_rt != 5'd0) &&
                         ((ex_rt == id_rs) || (w_rt_read && (ex_rt == id_rt)));
    assign w_mem_stall = mem_req && !mem_ready;
    assign w_is_j      = (id_op == OP_J);

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_exmem_hold  = 1'b0;
        w_next_state  = ST_RUN;
        w_wait_active = 1'b0;
        if (rst_n) begin
            case (r_state)
                ST_RUN, ST_LU_STALL: begin
                    if (w_mem_stall) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_exmem_hold  = 1'b1;
                        w_next_state  = ST_MEM_WAIT;
                        w_wait_active = 1'b1;
                    end else if (ex_branch_taken) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_bubble = 1'b1;
                    end else if (w_lu && (r_state == ST_RUN)) begin
                        // In LU_STALL, EX already holds the bubble so lu cannot fire again.
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_bubble = 1'b1;
                        w_next_state  = ST_LU_STALL;
                    end else if (w_is_j) begin
                        w_ifid_flush  = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_exmem_hold  = 1'b1;
                        w_next_state  = ST_MEM_WAIT;
                        w_wait_active = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        w_wait_next = r_wait_cnt;
        if (r_state != ST_MEM_WAIT) begin
            w_wait_next = 8'd1;
        end else if (r_wait_cnt != LP_WAIT_SAT) begin
            w_wait_next = r_wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_wait_active) begin
                r_wait_cnt <= w_wait_next;
                if (w_wait_next >= LP_MAX_WAIT) begin
                    r_mem_timeout <= 1'b1;
                end
            end
            if (!w_pc_write && (r_stall_cnt != LP_CNT_SAT)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_ifid_flush && (r_flush_cnt != LP_CNT_SAT)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign pc_write    = w_pc_write;
    assign ifid_write  = w_ifid_write;
    assign ifid_flush  = w_ifid_flush;
    assign idex_bubble = w_idex_bubble;
    assign exmem_hold  = w_exmem_hold;
    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       exmem_hold;
    logic       mem_timeout;
    logic [1:0] stall_cnt;
    logic [1:0] flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(2), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_hold(exmem_hold), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] exp_q[$];
    int         id_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    function automatic logic [9:0] E(input logic pcw, ifw, fl, bub, hold, to,
                                     input logic [1:0] sc, fc);
        return {pcw, ifw, fl, bub, hold, to, sc, fc};
    endfunction

    task automatic step(input int id, input logic rst, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt, input logic exmr,
                        input logic [4:0] exrt, input logic br, input logic mreq,
                        input logic mrdy, input logic [9:0] exp, input logic chk);
        @(posedge clk);
        #1;
        rst_n = rst; id_op = op; id_rs = rs; id_rt = rt;
        ex_mem_read = exmr; ex_rt = exrt; ex_branch_taken = br;
        mem_req = mreq; mem_ready = mrdy;
        if (chk) begin
            exp_q.push_back(exp);
            id_q.push_back(id);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            logic [9:0] a;
            int         sid;
            e   = exp_q.pop_front();
            sid = id_q.pop_front();
            a   = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold,
                   mem_timeout, stall_cnt, flush_cnt};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL step%0d {pcw,ifw,fl,bub,hold,to,sc,fc} got=%b want=%b", sid, a, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; id_op = '0; id_rs = '0; id_rt = '0; ex_mem_read = 1'b0;
        ex_rt = '0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,0,0), 0);
        // reset forces defaults despite hostile inputs
        step(1, 0, 0, 1, 5, 1, 5, 1, 1, 0, E(1,1,0,0,0,0,0,0), 1);
        // load-use stall and filtering
        step(2, 1, 0, 1, 5, 1, 5, 0, 0, 0, E(0,0,0,1,0,0,0,0), 1);
        step(3, 1, 0, 1, 5, 1, 5, 0, 0, 0, E(1,1,0,0,0,0,1,0), 1);
        step(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,1,0), 1);
        step(5, 1, 0, 0, 0, 1, 0, 0, 0, 0, E(1,1,0,0,0,0,1,0), 1);
        step(6, 1, 8, 1, 5, 1, 5, 0, 0, 0, E(1,1,0,0,0,0,1,0), 1);
        step(7, 1, 8, 5, 0, 1, 5, 0, 0, 0, E(0,0,0,1,0,0,1,0), 1);
        step(8, 1, 2, 0, 0, 0, 0, 0, 0, 0, E(1,1,1,0,0,0,2,0), 1);
        step(9, 1, 43, 0, 7, 1, 7, 0, 0, 0, E(0,0,0,1,0,0,2,1), 1);
        step(10, 1, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,3,1), 1);
        // branch beats lu, jumps, flush counter saturation
        step(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,3,1), 1);
        step(12, 1, 0, 1, 5, 1, 5, 1, 0, 0, E(1,1,1,1,0,0,0,0), 1);
        step(13, 1, 0, 1, 5, 1, 5, 0, 0, 0, E(0,0,0,1,0,0,0,1), 1);
        step(14, 1, 0, 0, 0, 0, 0, 1, 0, 0, E(1,1,1,1,0,0,1,1), 1);
        step(15, 1, 2, 0, 0, 0, 0, 0, 0, 0, E(1,1,1,0,0,0,1,2), 1);
        step(16, 1, 2, 0, 0, 0, 0, 0, 0, 0, E(1,1,1,0,0,0,1,3), 1);
        step(17, 1, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,1,3), 1);
        // memory wait of three cycles, events ignored meanwhile
        step(18, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,1,3), 1);
        step(19, 1, 2, 0, 0, 0, 0, 1, 1, 0, E(0,0,0,0,1,0,0,0), 1);
        step(20, 1, 2, 0, 0, 0, 0, 1, 1, 0, E(0,0,0,0,1,0,1,0), 1);
        step(21, 1, 0, 0, 0, 0, 0, 0, 1, 0, E(0,0,0,0,1,0,2,0), 1);
        step(22, 1, 0, 0, 0, 0, 0, 1, 1, 1, E(1,1,0,0,0,0,3,0), 1);
        step(23, 1, 0, 0, 0, 0, 0, 1, 0, 0, E(1,1,1,1,0,0,3,0), 1);
        step(24, 1, 0, 0, 0, 0, 0, 0, 1, 1, E(1,1,0,0,0,0,3,1), 1);
        // timeout after four waited cycles, sticky
        step(25, 0, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,3,1), 1);
        step(26, 1, 0, 0, 0, 0, 0, 0, 1, 0, E(0,0,0,0,1,0,0,0), 1);
        step(27, 1, 0, 0, 0, 0, 0, 0, 1, 0, E(0,0,0,0,1,0,1,0), 1);
        step(28, 1, 0, 0, 0, 0, 0, 0, 1, 0, E(0,0,0,0,1,0,2,0), 1);
        step(29, 1, 0, 0, 0, 0, 0, 0, 1, 0, E(0,0,0,0,1,0,3,0), 1);
        step(30, 1, 0, 0, 0, 0, 0, 0, 1, 0, E(0,0,0,0,1,1,3,0), 1);
        step(31, 1, 0, 0, 0, 0, 0, 0, 1, 0, E(0,0,0,0,1,1,3,0), 1);
        step(32, 1, 0, 0, 0, 0, 0, 0, 1, 1, E(1,1,0,0,0,1,3,0), 1);
        step(33, 1, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,1,3,0), 1);
        // reset aborts MEM_WAIT and LU_STALL
        step(34, 1, 0, 0, 0, 0, 0, 0, 1, 0, E(0,0,0,0,1,1,3,0), 1);
        step(35, 0, 0, 0, 0, 0, 0, 0, 1, 0, E(1,1,0,0,0,1,3,0), 1);
        step(36, 1, 0, 0, 0, 0, 0, 1, 0, 0, E(1,1,1,1,0,0,0,0), 1);
        step(37, 1, 0, 1, 5, 1, 5, 0, 0, 0, E(0,0,0,1,0,0,0,1), 1);
        step(38, 0, 0, 1, 5, 1, 5, 0, 0, 0, E(1,1,0,0,0,0,1,1), 1);
        step(39, 1, 0, 1, 5, 1, 5, 0, 0, 0, E(0,0,0,1,0,0,0,0), 1);
        // memory wait takes priority inside LU_STALL
        step(40, 1, 0, 0, 0, 0, 0, 0, 1, 0, E(0,0,0,0,1,0,1,0), 1);
        step(41, 1, 0, 0, 0, 0, 0, 0, 1, 1, E(1,1,0,0,0,0,2,0), 1);
        step(42, 1, 0, 0, 0, 0, 0, 0, 0, 0, E(1,1,0,0,0,0,2,0), 1);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
